// File: rtl/ad9518_pkg.sv
// Shared state type, register addresses and timer width for the AD9518 sequencer.
package ad9518_pkg;

    localparam logic [15:0] REG_SOFT_RESET   = 16'h0000;
    localparam logic [15:0] REG_PLL_CTRL3    = 16'h0018;
    localparam logic [15:0] REG_PLL_READBACK = 16'h001F;
    localparam logic [15:0] REG_UPDATE       = 16'h0232;

    localparam logic [23:0] LUT_END = 24'hFFFFFF;

    localparam int CAL_WAIT_MAX = 50000;
    localparam int DLY_W        = $clog2(CAL_WAIT_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_REQ,
        S_DELAY,
        S_NEXT,
        S_DONE,
        S_ERR
`ifdef AD9518_LOCK_POLL_EN
        ,
        S_POLL_REQ,
        S_POLL_GAP
`endif
    } state_t;

endpackage

// File: rtl/ad9518_wait_timer.sv
// Loadable down-counter with a one-cycle expire pulse; shared by settle delays and ack timeout.
module ad9518_wait_timer
    import ad9518_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DLY_W-1:0] load_val,
    input  logic             en,
    output logic             expire
);

    logic [DLY_W-1:0] cnt;

    // A zero load still yields one counted cycle so the caller never stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (load_val == '0) ? DLY_W'(1) : load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = en && (cnt == DLY_W'(1));

endmodule

// File: rtl/ad9518_cfg_ctrl.sv
// AD9518 power-up sequencer: walks the register LUT and issues one SPI write per entry.
// Define AD9518_LOCK_POLL_EN to poll PLL lock readback (0x001F) after the last write.
module ad9518_cfg_ctrl
    import ad9518_pkg::*;
#(
    parameter int LUT_SIZE       = 37,
    parameter int RESET_WAIT_CYC = 1000,
    parameter int CAL_WAIT_CYC   = 50000,
    parameter int GAP_CYC        = 4,
    parameter int ACK_TIMEOUT    = 4096
`ifdef AD9518_LOCK_POLL_EN
    ,
    parameter int LOCK_POLLS     = 256
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [9:0]  lut_index,
    input  logic [23:0] lut_data,
    output logic        spi_req,
    output logic        spi_rw,
    output logic [15:0] spi_addr,
    output logic [7:0]  spi_wdata,
    input  logic        spi_ack,
    input  logic [7:0]  spi_rdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        pll_locked
);

    state_t           state;
    logic             tmr_load;
    logic [DLY_W-1:0] tmr_val;
    logic             tmr_en;
    logic             tmr_expire;
    logic [DLY_W-1:0] settle;
    logic             is_end;
    logic             rdata_unused;

`ifdef AD9518_LOCK_POLL_EN
    localparam int PW = $clog2(LOCK_POLLS + 1);
    logic [PW-1:0] polls;
`endif

    assign is_end       = (lut_index == 10'(LUT_SIZE)) || (lut_data == LUT_END);
    assign rdata_unused = ^spi_rdata;

    // Settle time owed after the entry currently held in spi_addr/spi_wdata.
    always_comb begin
        settle = DLY_W'(GAP_CYC);
        unique case (1'b1)
            (spi_addr == REG_SOFT_RESET) && (spi_wdata[5] || spi_wdata[2]):
                settle = DLY_W'(RESET_WAIT_CYC);
            (spi_addr == REG_PLL_CTRL3) && spi_wdata[0]:
                settle = DLY_W'(CAL_WAIT_CYC);
            default: ;
        endcase
    end

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = DLY_W'(ACK_TIMEOUT);
        unique case (state)
            S_FETCH: tmr_load = 1'b1;
            S_REQ: begin
                tmr_load = spi_ack;
                tmr_val  = settle;
            end
`ifdef AD9518_LOCK_POLL_EN
            S_POLL_REQ: begin
                tmr_load = spi_ack;
                tmr_val  = DLY_W'(GAP_CYC);
            end
            S_POLL_GAP: tmr_load = tmr_expire;
`endif
            default: ;
        endcase
    end

`ifdef AD9518_LOCK_POLL_EN
    assign tmr_en = (state == S_REQ) || (state == S_DELAY)
                 || (state == S_POLL_REQ) || (state == S_POLL_GAP);
`else
    assign tmr_en = (state == S_REQ) || (state == S_DELAY);
    assign spi_rw     = 1'b0;
    assign pll_locked = 1'b0;
`endif

    ad9518_wait_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            lut_index <= '0;
            spi_req   <= 1'b0;
            spi_addr  <= '0;
            spi_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
`ifdef AD9518_LOCK_POLL_EN
            spi_rw     <= 1'b0;
            pll_locked <= 1'b0;
            polls      <= '0;
`endif
        end else begin
            unique case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        done      <= 1'b0;
                        error     <= 1'b0;
                        busy      <= 1'b1;
                        lut_index <= '0;
                        state     <= S_FETCH;
`ifdef AD9518_LOCK_POLL_EN
                        pll_locked <= 1'b0;
                        polls      <= '0;
`endif
                    end
                end
                S_FETCH: begin
                    if (is_end) begin
`ifdef AD9518_LOCK_POLL_EN
                        spi_req   <= 1'b1;
                        spi_rw    <= 1'b1;
                        spi_addr  <= REG_PLL_READBACK;
                        spi_wdata <= '0;
                        state     <= S_POLL_REQ;
`else
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
`endif
                    end else begin
                        spi_req   <= 1'b1;
                        spi_addr  <= lut_data[23:8];
                        spi_wdata <= lut_data[7:0];
                        state     <= S_REQ;
`ifdef AD9518_LOCK_POLL_EN
                        spi_rw    <= 1'b0;
`endif
                    end
                end
                S_REQ: begin
                    if (spi_ack) begin
                        spi_req <= 1'b0;
                        state   <= S_DELAY;
                    end else if (tmr_expire) begin
                        spi_req <= 1'b0;
                        busy    <= 1'b0;
                        error   <= 1'b1;
                        state   <= S_ERR;
                    end
                end
                S_DELAY: begin
                    if (tmr_expire) state <= S_NEXT;
                end
                S_NEXT: begin
                    lut_index <= lut_index + 1'b1;
                    state     <= S_FETCH;
                end
`ifdef AD9518_LOCK_POLL_EN
                S_POLL_REQ: begin
                    if (spi_ack) begin
                        spi_req <= 1'b0;
                        if (spi_rdata[0]) begin
                            pll_locked <= 1'b1;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            state      <= S_DONE;
                        end else if (polls == PW'(LOCK_POLLS - 1)) begin
                            busy  <= 1'b0;
                            error <= 1'b1;
                            state <= S_ERR;
                        end else begin
                            polls <= polls + 1'b1;
                            state <= S_POLL_GAP;
                        end
                    end else if (tmr_expire) begin
                        spi_req <= 1'b0;
                        busy    <= 1'b0;
                        error   <= 1'b1;
                        state   <= S_ERR;
                    end
                end
                S_POLL_GAP: begin
                    if (tmr_expire) begin
                        spi_req <= 1'b1;
                        state   <= S_POLL_REQ;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ad9518_cfg_ctrl.sv
// Scoreboard bench for ad9518_cfg_ctrl: random LUT contents against a LUT-walking reference model.
// Build with AD9518_LOCK_POLL_EN to also exercise the lock readback poll.
module tb_ad9518_cfg_ctrl;

    localparam int LUT_SIZE = 37;
    localparam int RST_WAIT = 20;
    localparam int CAL_WAIT = 100;
    localparam int GAP      = 4;
    localparam int ACK_TO   = 4096;
    localparam int ACK_DLY  = 8;
`ifdef AD9518_LOCK_POLL_EN
    localparam bit POLL_EN = 1'b1;
    localparam int POLLS   = 4;
`else
    localparam bit POLL_EN = 1'b0;
    localparam int POLLS   = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  lut_index;
    logic [23:0] lut_data;
    logic        spi_req;
    logic        spi_rw;
    logic [15:0] spi_addr;
    logic [7:0]  spi_wdata;
    logic        spi_ack;
    logic [7:0]  spi_rdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        pll_locked;

    logic [23:0] lut [0:1023];
    assign lut_data = lut[lut_index];

    always #5 clk = ~clk;

    ad9518_cfg_ctrl #(
        .LUT_SIZE       (LUT_SIZE),
        .RESET_WAIT_CYC (RST_WAIT),
        .CAL_WAIT_CYC   (CAL_WAIT),
        .GAP_CYC        (GAP),
        .ACK_TIMEOUT    (ACK_TO)
`ifdef AD9518_LOCK_POLL_EN
        ,
        .LOCK_POLLS     (POLLS)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .lut_index  (lut_index),
        .lut_data   (lut_data),
        .spi_req    (spi_req),
        .spi_rw     (spi_rw),
        .spi_addr   (spi_addr),
        .spi_wdata  (spi_wdata),
        .spi_ack    (spi_ack),
        .spi_rdata  (spi_rdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .pll_locked (pll_locked)
    );

    typedef struct {
        logic [24:0] txn;
        int          gap;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    bit   silent = 1'b0;
    int   silent_idx = 0;
    int   pf_cfg = 0;
    int   reads = 0;
    int   exp_end_idx;
    int   exp_reads;
    bit   exp_done;
    bit   exp_err;
    bit   exp_lock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, got, want);
    endtask

    function automatic int settle_of(input logic [23:0] e);
        if (e[23:8] == 16'h0000 && (e[5] || e[2])) return RST_WAIT;
        if (e[23:8] == 16'h0018 && e[0]) return CAL_WAIT;
        return GAP;
    endfunction

    // Expected SPI traffic for one run; gap is the spi_req-low time before the
    // next request (settle delay plus the NEXT and FETCH cycles), -1 if none.
    task automatic model_run(input int stop_at, input int pf);
        exp_t e;
        int   i;
        bit   more;
        exp_q.delete();
        i = 0;
        while (i < LUT_SIZE && lut[i] != 24'hFFFFFF && (stop_at < 0 || i < stop_at)) begin
            more  = (i + 1 < LUT_SIZE && lut[i + 1] != 24'hFFFFFF) || POLL_EN;
            e.txn = {1'b0, lut[i]};
            e.gap = more ? settle_of(lut[i]) + 2 : -1;
            exp_q.push_back(e);
            i++;
        end
        exp_end_idx = i;
        exp_done    = 1'b1;
        exp_err     = 1'b0;
        exp_lock    = 1'b0;
        exp_reads   = 0;
        if (POLL_EN && stop_at < 0) begin
            exp_reads = (pf < POLLS) ? pf + 1 : POLLS;
            exp_lock  = (pf < POLLS);
            exp_done  = exp_lock;
            exp_err   = !exp_lock;
            for (int k = 0; k < exp_reads; k++) begin
                e.txn = {1'b1, 16'h001F, 8'h00};
                e.gap = (k < exp_reads - 1) ? GAP : -1;
                exp_q.push_back(e);
            end
        end
    endtask

    function automatic logic [23:0] rand_entry();
        logic [7:0] d;
        d = 8'($urandom);
        case ($urandom_range(0, 5))
            0:       return {16'h0000, d};
            1:       return {16'h0018, d};
            default: return {16'h0100 + 16'($urandom_range(0, 255)), d};
        endcase
    endfunction

    initial begin : ack_model
        int age;
        age       = 0;
        spi_ack   = 1'b0;
        spi_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            spi_ack = 1'b0;
            age = spi_req ? age + 1 : 0;
            if (spi_req && age == ACK_DLY && !(silent && lut_index == 10'(silent_idx))) begin
                spi_ack = 1'b1;
                if (spi_rw) begin
                    spi_rdata = {7'($urandom), 1'(reads >= pf_cfg)};
                    reads++;
                end else begin
                    spi_rdata = 8'($urandom);
                end
            end
        end
    end

    initial begin : monitor
        int          lo;
        int          want_gap;
        bit          meas;
        logic [24:0] got;
        exp_t        e;
        lo   = 0;
        meas = 1'b0;
        want_gap = 0;
        forever begin
            @(negedge clk);
            if (meas) begin
                if (spi_req) begin
                    check("gap", 32'(lo), 32'(want_gap));
                    meas = 1'b0;
                end else begin
                    lo++;
                end
            end
            if (spi_req && spi_ack) begin
                got = {spi_rw, spi_addr, spi_wdata};
                if (got[24]) got[7:0] = 8'h00;
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL extra_txn: got %h, required none", got);
                end else begin
                    e = exp_q.pop_front();
                    check("txn", 32'(got), 32'(e.txn));
                    if (e.gap >= 0) begin
                        meas     = 1'b1;
                        lo       = 0;
                        want_gap = e.gap;
                    end
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_run(input string tag);
        int n;
        n = 0;
        while (!(done || error) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ended"}, 32'(done || error), 32'd1);
        repeat (20) @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_error"}, 32'(error), 32'(exp_err));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_locked"}, 32'(pll_locked), 32'(exp_lock));
        check({tag, "_end_index"}, 32'(lut_index), 32'(exp_end_idx));
        check({tag, "_reads"}, 32'(reads), 32'(exp_reads));
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic full_run(input string tag, input int pf);
        pf_cfg = pf;
        reads  = 0;
        model_run(-1, pf);
        pulse_start();
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        repeat (30) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_run(tag);
    endtask

    task automatic wait_req_at(input int idx, output bit ok);
        int n;
        n = 0;
        while (!(spi_req && lut_index == 10'(idx)) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        ok = spi_req && (lut_index == 10'(idx));
    endtask

    initial begin : main
        bit          ok;
        bit          saw;
        int          hi;
        logic [23:0] saved;

        for (int i = 0; i < 1024; i++) lut[i] = rand_entry();
        lut[0]  = 24'h00003C;
        lut[3]  = 24'h001807;
        lut[4]  = 24'h001806;
        lut[5]  = {16'h0013, 8'($urandom)};
        lut[36] = 24'h023201;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req", 32'(spi_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_index", 32'(lut_index), 32'd0);
        check("rst_locked", 32'(pll_locked), 32'd0);
        check("rst_rw", 32'(spi_rw), 32'd0);
        check("rst_addr", 32'(spi_addr), 32'd0);
        check("rst_wdata", 32'(spi_wdata), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        full_run("full", 0);

        silent     = 1'b1;
        silent_idx = 5;
        pf_cfg     = 0;
        reads      = 0;
        model_run(5, 0);
        pulse_start();
        wait_req_at(5, ok);
        check("to_reached", 32'(ok), 32'd1);
        hi = 1;
        while (spi_req && hi < 6000) begin
            @(negedge clk);
            if (spi_req) hi++;
        end
        check("to_req_cycles", 32'(hi), 32'(ACK_TO));
        @(negedge clk);
        check("to_error", 32'(error), 32'd1);
        check("to_done", 32'(done), 32'd0);
        check("to_busy", 32'(busy), 32'd0);
        check("to_index", 32'(lut_index), 32'd5);
        saw = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (spi_req) saw = 1'b1;
        end
        check("to_quiet", 32'(saw), 32'd0);
        check("to_pending", 32'(exp_q.size()), 32'd0);
        silent = 1'b0;

        full_run("restart", 0);

        reads = 0;
        model_run(10, 0);
        pulse_start();
        wait_req_at(10, ok);
        check("rr_reached", 32'(ok), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rr_req", 32'(spi_req), 32'd0);
        check("rr_busy", 32'(busy), 32'd0);
        check("rr_index", 32'(lut_index), 32'd0);
        check("rr_pending", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rr_idle", 32'(busy || spi_req || done || error), 32'd0);

        saved   = lut[20];
        lut[20] = 24'hFFFFFF;
        full_run("sentinel", 0);
        lut[20] = saved;

`ifdef AD9518_LOCK_POLL_EN
        full_run("lock3", 3);
        full_run("nolock", 1000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
